// File: rtl/pwm_output_stage.sv
// pwm_output_stage: drives the 16 user output pins from the SPI register file.
// Each pin is either forced low, forced high, or driven by a shared 8-bit PWM
// waveform. The duty cycle is latched into a shadow register at each period
// boundary, so a register write never produces a runt pulse.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-high reset
//   en_reg_out_7_0   output enable, pins 7..0
//   en_reg_out_15_8  output enable, pins 15..8
//   en_reg_pwm_7_0   PWM mode select, pins 7..0
//   en_reg_pwm_15_8  PWM mode select, pins 15..8
//   pwm_duty_cycle   shared duty value, 0x00..0xFF (0xFF = constant high)
//   out              registered pin drive, bit i is pin i
//   period_start     registered one-cycle strobe at the start of each period
module pwm_output_stage #(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned PIN_W   = 16;
   localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   logic [PRESC_W-1:0] presc;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   duty_sh;
   logic               wrap_q;

   logic               tick_c;
   logic               wrap_c;
   logic               level_c;
   logic [PIN_W-1:0]   en_out_c;
   logic [PIN_W-1:0]   en_pwm_c;
   logic [PIN_W-1:0]   out_nxt_c;

   // Count step, period wrap, PWM level and per-pin mode select.
   always_comb begin
      tick_c    = (presc == PRESC_MAX);
      wrap_c    = tick_c && (cnt == CNT_MAX);
      // Full-scale duty means constant high rather than 255/256.
      level_c   = (duty_sh == CNT_MAX) || (cnt < duty_sh);
      en_out_c  = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm_c  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      out_nxt_c = en_out_c & (~en_pwm_c | {PIN_W{level_c}});
   end

   // Prescaler, PWM counter, duty shadow and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc        <= '0;
         cnt          <= '0;
         duty_sh      <= '0;
         wrap_q       <= 1'b0;
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         if (tick_c) begin
            presc <= '0;
            cnt   <= cnt + CNT_W'(1);
         end else begin
            presc <= presc + PRESC_W'(1);
         end
         // Shadow samples the duty input present on the wrap edge itself.
         if (wrap_c) begin
            duty_sh <= pwm_duty_cycle;
         end
         // Strobe is delayed one extra cycle so it lines up with the first
         // out value computed from cnt=0 and the freshly loaded shadow.
         wrap_q       <= wrap_c;
         period_start <= wrap_q;
         out          <= out_nxt_c;
      end
   end

endmodule

// File: tb/tb_pwm_output_stage.sv
// tb_pwm_output_stage: directed test of pwm_output_stage with CLK_DIV=2
// (512-cycle period). Outputs are sampled 1 time unit after each rising edge.
module tb_pwm_output_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   int vectors     = 0;
   int miscompares = 0;

   int   hi_cnt [16];
   int   per_len;
   logic last_lvl;
   int   low_bad;
   int   ps_seen;

   logic [7:0] duties [5] = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
   int         exp_hi [5] = '{0, 2, 256, 508, 512};

   pwm_output_stage #(.CLK_DIV(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      {en_reg_out_15_8, en_reg_out_7_0} = eo;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
   endtask

   // Align to the next period_start sample, then count per-pin high samples
   // until the following period_start. Optionally writes the duty input at
   // sample offset wr_at within the measured period (-1 = no write).
   task automatic measure(input int wr_at, input logic [7:0] wr_val);
      int guard = 0;
      while (period_start !== 1'b1 && guard < 2000) begin
         step();
         guard++;
      end
      per_len  = 0;
      last_lvl = 1'b0;
      for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
      do begin
         for (int i = 0; i < 16; i++) hi_cnt[i] += (out[i] === 1'b1) ? 1 : 0;
         last_lvl = out[0];
         if (per_len == wr_at) pwm_duty_cycle = wr_val;
         per_len++;
         step();
      end while (period_start !== 1'b1 && per_len < 2000);
   endtask

   initial begin
      // Reset with random inputs
      rst = 1'b1;
      set_en(16'($urandom), 16'($urandom));
      pwm_duty_cycle = 8'($urandom);
      repeat (3) step();
      check("rst_out", 32'(out), 32'h0);
      check("rst_ps", 32'(period_start), 32'h0);

      // Release with all pins forced high
      set_en(16'hFFFF, 16'h0000);
      pwm_duty_cycle = 8'h00;
      rst = 1'b0;
      check("rel_out_before_edge", 32'(out), 32'h0);
      step();
      check("rel_out_forced_high", 32'(out), 32'hFFFF);
      check("rel_ps", 32'(period_start), 32'h0);

      // Duty sweep on all pins
      set_en(16'hFFFF, 16'hFFFF);
      for (int d = 0; d < 5; d++) begin
         pwm_duty_cycle = duties[d];
         step();
         measure(-1, 8'h00);
         check($sformatf("sweep_hi_%02h", duties[d]), 32'(hi_cnt[0]), 32'(exp_hi[d]));
         check($sformatf("sweep_hi15_%02h", duties[d]), 32'(hi_cnt[15]), 32'(exp_hi[d]));
         check($sformatf("sweep_len_%02h", duties[d]), 32'(per_len), 32'd512);
      end

      // Mixed modes
      set_en(16'h00F0, 16'h0030);
      pwm_duty_cycle = 8'h40;
      step();
      measure(-1, 8'h00);
      measure(-1, 8'h00);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("mixed_pin%0d", i), 32'(hi_cnt[i]),
               (i == 4 || i == 5) ? 32'd128 : ((i == 6 || i == 7) ? 32'd512 : 32'd0));
      end

      // Double buffering: write 0xC0 mid-period at cnt=100
      set_en(16'hFFFF, 16'hFFFF);
      step();
      measure(-1, 8'h00);
      check("dbuf_settle_hi", 32'(hi_cnt[0]), 32'd128);
      measure(200, 8'hC0);
      check("dbuf_cur_hi", 32'(hi_cnt[0]), 32'd128);
      check("dbuf_cur_len", 32'(per_len), 32'd512);
      measure(-1, 8'h00);
      check("dbuf_next_hi", 32'(hi_cnt[0]), 32'd384);
      check("dbuf_next_len", 32'(per_len), 32'd512);
      check("dbuf_fall_before_ps", 32'(last_lvl), 32'h0);
      check("dbuf_rise_at_ps", 32'(out), 32'hFFFF);

      // Boundary writes: on the wrap edge, then one cycle after it
      measure(510, 8'h10);
      check("bnd_on_cur_hi", 32'(hi_cnt[0]), 32'd384);
      measure(-1, 8'h00);
      check("bnd_on_next_hi", 32'(hi_cnt[0]), 32'd32);
      measure(511, 8'h20);
      check("bnd_late_cur_hi", 32'(hi_cnt[0]), 32'd32);
      measure(-1, 8'h00);
      check("bnd_late_next_hi", 32'(hi_cnt[0]), 32'd32);
      measure(-1, 8'h00);
      check("bnd_late_after_hi", 32'(hi_cnt[0]), 32'd64);

      // Reset mid-period at cnt=77 with duty 0x80
      pwm_duty_cycle = 8'h80;
      measure(-1, 8'h00);
      check("mid_prev_hi", 32'(hi_cnt[0]), 32'd64);
      check("mid_ps_out", 32'(out), 32'hFFFF);
      repeat (153) step();
      check("mid_pre_rst_out", 32'(out), 32'hFFFF);
      rst = 1'b1;
      #1;
      check("mid_async_out", 32'(out), 32'h0);
      check("mid_async_ps", 32'(period_start), 32'h0);
      repeat (3) step();
      rst = 1'b0;
      step();
      low_bad = 0;
      ps_seen = 0;
      for (int i = 0; i < 512; i++) begin
         if (out !== 16'h0000) low_bad++;
         if (period_start !== 1'b0) ps_seen++;
         step();
      end
      check("post_rst_high_samples", 32'(low_bad), 32'd0);
      check("post_rst_ps_count", 32'(ps_seen), 32'd0);
      check("post_rst_first_ps", 32'(period_start), 32'h1);
      check("post_rst_first_out", 32'(out), 32'hFFFF);
      measure(-1, 8'h00);
      check("post_rst_hi", 32'(hi_cnt[0]), 32'd256);
      check("post_rst_len", 32'(per_len), 32'd512);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
